// File: rtl/bpred_pkg.sv
// +------------------------------------------------------------------+
// | bpred_pkg : shared fetch/execute/resolve types for the predictor |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package bpred_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;

  typedef logic bool;
  localparam bool TRUE  = 1'b1;
  localparam bool FALSE = 1'b0;

  typedef enum logic {
    BRC_JUMP   = 1'b0,
    BRC_BRANCH = 1'b1
  } brc_ty_t;

  typedef logic [1:0] bpred_ctr_t;

  localparam bpred_ctr_t CTR_RESET    = 2'b01;
  localparam bpred_ctr_t CTR_ALLOC_BR = 2'b10;
  localparam bpred_ctr_t CTR_STRONG_T = 2'b11;

endpackage

`default_nettype wire

// File: rtl/bpred_ctr_next.sv
// +------------------------------------------------------------------+
// | bpred_ctr_next : next-state rule for one 2-bit saturating counter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bpred_ctr_next
  import bpred_pkg::*;
(
  input  bpred_ctr_t cur_ctr,
  input  logic       hit,
  input  brc_ty_t    ty,
  input  logic       taken,
  output bpred_ctr_t next_ctr
);

  always_comb begin
    next_ctr = cur_ctr;
    if (hit) begin
      if (ty == BRC_JUMP) begin
        next_ctr = CTR_STRONG_T;
      end else if (taken) begin
        if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'd1;
      end else begin
        if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'd1;
      end
    end else if (taken) begin
      // fresh allocation: jumps start saturated, branches weakly taken
      next_ctr = (ty == BRC_JUMP) ? CTR_STRONG_T : CTR_ALLOC_BR;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bpred.sv
// +------------------------------------------------------------------+
// | bpred : direct-mapped BTB with 2-bit counters, 1-cycle lookup     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bpred
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    lookup_valid,
  input  xlen_t   lookup_pc,
  input  logic    flush,
  output logic    pred_valid,
  output bool     pred_taken,
  output xlen_t   pred_target,
  input  logic    upd_valid,
  input  xlen_t   upd_pc,
  input  brc_ty_t upd_ty,
  input  logic    upd_taken,
  input  xlen_t   upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  bpred_ctr_t         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  xlen_t              r_target [ENTRIES];

  logic    r_pred_valid;
  bool     r_pred_taken;
  xlen_t   r_pred_target;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  bpred_ctr_t       w_ctr_next;
  logic             w_unused;

  assign w_lk_idx  = lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = lookup_pc[XLEN-1:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_unused  = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

  assign w_lk_hit  = r_valid[w_lk_idx]  && (r_tag[w_lk_idx]  == w_lk_tag);
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  bpred_ctr_next u_ctr_next (
    .cur_ctr  (r_ctr[w_upd_idx]),
    .hit      (w_upd_hit),
    .ty       (upd_ty),
    .taken    (upd_taken),
    .next_ctr (w_ctr_next)
  );

  // Lookup reads current array state, so a same-cycle update is not visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= FALSE;
      r_pred_target <= '0;
    end else if (lookup_valid && !flush) begin
      r_pred_valid  <= 1'b1;
      r_pred_taken  <= w_lk_hit && r_ctr[w_lk_idx][1];
      r_pred_target <= (w_lk_hit && r_ctr[w_lk_idx][1]) ? r_target[w_lk_idx]
                                                         : lookup_pc + xlen_t'(4);
    end else begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= FALSE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (upd_valid && (w_upd_hit || upd_taken)) begin
      r_valid[w_upd_idx] <= 1'b1;
      r_ctr[w_upd_idx]   <= w_ctr_next;
    end
  end

  // Tag and target storage carries no reset; valid bits guard it.
  always_ff @(posedge clock) begin
    if (!reset && upd_valid) begin
      if (!w_upd_hit && upd_taken) begin
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
      end else if (w_upd_hit && ((upd_ty == BRC_JUMP) || upd_taken)) begin
        r_target[w_upd_idx] <= upd_target;
      end
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_taken  = r_pred_taken;
  assign pred_target = r_pred_target;

endmodule

`default_nettype wire

// File: tb/tb_bpred.sv
// +------------------------------------------------------------------+
// | tb_bpred : directed self-checking bench for bpred                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_bpred;
  import bpred_pkg::*;

  logic    clock = 1'b0;
  logic    reset;
  logic    lookup_valid;
  xlen_t   lookup_pc;
  logic    flush;
  logic    pred_valid;
  bool     pred_taken;
  xlen_t   pred_target;
  logic    upd_valid;
  xlen_t   upd_pc;
  brc_ty_t upd_ty;
  logic    upd_taken;
  xlen_t   upd_target;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bpred #(.ENTRIES(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .flush        (flush),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_ty       (upd_ty),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    lookup_valid = 1'b0;
    flush        = 1'b0;
    upd_valid    = 1'b0;
  endtask

  task automatic lookup(input xlen_t pc, input logic fl);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    flush        = fl;
  endtask

  task automatic update(input xlen_t pc, input brc_ty_t ty, input logic tk, input xlen_t tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_ty     = ty;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic expect_pred(input string tag, input logic v, input logic tk, input xlen_t tgt);
    check({tag, ".valid"},  32'(v),  32'(pred_valid));
    check({tag, ".taken"},  32'(tk), 32'(pred_taken));
    check({tag, ".target"}, tgt,     pred_target);
  endtask

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_ty = BRC_BRANCH; upd_taken = 1'b0; upd_target = '0;
    @(negedge clock);
    tick(); tick();
    check("rst.valid", 32'(pred_valid), 32'd0);
    check("rst.taken", 32'(pred_taken), 32'd0);
    check("rst.target", pred_target, 32'h0);
    check("rst.ctr", 32'(dut.r_ctr[0]), 32'd1);
    reset = 1'b0;

    lookup(32'h0000_1000, 1'b0); tick();
    expect_pred("cold", 1'b1, 1'b0, 32'h0000_1004);

    update(32'h1000, BRC_BRANCH, 1'b1, 32'h2000); tick();
    check("idle.valid", 32'(pred_valid), 32'd0);
    check("alloc.ctr", 32'(dut.r_ctr[0]), 32'd2);
    lookup(32'h1000, 1'b0); tick();
    expect_pred("br_alloc", 1'b1, 1'b1, 32'h2000);

    update(32'h1000, BRC_BRANCH, 1'b1, 32'h2000); tick();
    update(32'h1000, BRC_BRANCH, 1'b1, 32'h2000); tick();
    check("sat.ctr", 32'(dut.r_ctr[0]), 32'd3);
    update(32'h1000, BRC_BRANCH, 1'b0, 32'h0); tick();
    check("nt1.ctr", 32'(dut.r_ctr[0]), 32'd2);
    lookup(32'h1000, 1'b0); tick();
    expect_pred("nt1", 1'b1, 1'b1, 32'h2000);
    update(32'h1000, BRC_BRANCH, 1'b0, 32'h0); tick();
    check("nt2.ctr", 32'(dut.r_ctr[0]), 32'd1);
    lookup(32'h1000, 1'b0); tick();
    expect_pred("nt2", 1'b1, 1'b0, 32'h1004);
    update(32'h1000, BRC_BRANCH, 1'b0, 32'h0); tick();
    update(32'h1000, BRC_BRANCH, 1'b0, 32'h0); tick();
    check("floor.ctr", 32'(dut.r_ctr[0]), 32'd0);

    update(32'h1100, BRC_JUMP, 1'b1, 32'h4000); tick();
    check("jmp.ctr", 32'(dut.r_ctr[0]), 32'd3);
    lookup(32'h1100, 1'b0); tick();
    expect_pred("jmp", 1'b1, 1'b1, 32'h4000);
    lookup(32'h1000, 1'b0); tick();
    expect_pred("alias", 1'b1, 1'b0, 32'h1004);

    lookup(32'h3000, 1'b0); update(32'h3000, BRC_BRANCH, 1'b1, 32'h5000); tick();
    expect_pred("rbw.old", 1'b1, 1'b0, 32'h3004);
    lookup(32'h3000, 1'b0); tick();
    expect_pred("rbw.new", 1'b1, 1'b1, 32'h5000);

    lookup(32'hFFFF_FFFC, 1'b1); tick();
    expect_pred("flush", 1'b0, 1'b0, 32'h5000);
    lookup(32'hFFFF_FFFC, 1'b0); tick();
    expect_pred("wrap", 1'b1, 1'b0, 32'h0000_0000);

    lookup(32'h3000, 1'b1); update(32'h2004, BRC_JUMP, 1'b1, 32'h6000); tick();
    check("flush_upd.valid", 32'(pred_valid), 32'd0);
    lookup(32'h2004, 1'b0); tick();
    expect_pred("flush_upd", 1'b1, 1'b1, 32'h6000);

    lookup(32'h3000, 1'b0); reset = 1'b1; tick();
    reset = 1'b0;
    expect_pred("mid_rst", 1'b0, 1'b0, 32'h0);
    lookup(32'h3000, 1'b0); tick();
    expect_pred("post_rst0", 1'b1, 1'b0, 32'h3004);
    lookup(32'h2004, 1'b0); tick();
    expect_pred("post_rst1", 1'b1, 1'b0, 32'h2008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
